// File: rtl/pattern_regfile.sv
// Register file that fills itself with one of four number patterns after a start pulse.
// reg[sel] is read out through a one-cycle registered port; reset is asynchronous and active-low.
module pattern_regfile #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] sel,
   output logic [2:0]        fsmState,
   output logic [DATA_W-1:0] currentResult,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_TWO  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEED = 3'd1,
      FILL = 3'd2,
      DONE = 3'd3
   } stateType;

   stateType          state;
   stateType          nextState;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        modeReg;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DATA_W-1:0] prev1;
   logic [DATA_W-1:0] prev2;
   logic [DATA_W-1:0] fillValue;
   logic [DATA_W-1:0] seed0;
   logic [DATA_W-1:0] seed1;
   logic              acceptStart;

   // A start is only honoured when no fill is in flight.
   assign acceptStart = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (start) nextState = SEED;
         SEED: nextState = FILL;
         FILL: if (idx == IDX_LAST) nextState = DONE;
         DONE: if (start) nextState = SEED;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      seed0 = '0;
      seed1 = '0;
      case (modeReg)
         2'b00: begin seed0 = DATA_W'(1); seed1 = DATA_W'(2); end
         2'b01: begin seed0 = DATA_W'(0); seed1 = DATA_W'(1); end
         2'b10: begin seed0 = DATA_W'(1); seed1 = DATA_W'(3); end
         default: begin seed0 = DATA_W'(0); seed1 = DATA_W'(1); end
      endcase
   end

   // Next pattern element from the two most recently written registers.
   always_comb begin
      prev1     = regs[idx - IDX_ONE];
      prev2     = regs[idx - IDX_TWO];
      fillValue = '0;
      case (modeReg)
         2'b00: fillValue = prev1 << 1;
         2'b01: fillValue = prev1 + prev2;
         2'b10: fillValue = (prev1 << 1) | DATA_W'(1);
         default: fillValue = prev1 + DATA_W'(1);
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         modeReg <= 2'b00;
      end else if (acceptStart) begin
         modeReg <= mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (state == SEED) begin
            regs[0] <= seed0;
            regs[1] <= seed1;
            idx     <= IDX_TWO;
         end else if (state == FILL) begin
            regs[idx] <= fillValue;
            idx       <= idx + IDX_ONE;
         end
      end
   end

   // Nonblocking update means a read of the index written this edge sees the old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         currentResult <= '0;
      end else begin
         currentResult <= regs[sel];
      end
   end

   assign fsmState = state;
   assign busy     = (state == SEED) || (state == FILL);
   assign done     = (state == DONE);

endmodule

// File: tb/tb_pattern_regfile.sv
// Self-checking bench for pattern_regfile: a 16-bit and an 8-bit instance share stimulus and are
// compared every cycle against an edge-count model, plus hand-computed register values.
module tb_pattern_regfile;

   localparam int DEPTH = 16;

   logic       clk;
   logic       reset;
   logic       start;
   logic [1:0] mode;
   logic [3:0] sel;

   logic [2:0]  fsmStateA;
   logic [15:0] resultA;
   logic        busyA;
   logic        doneA;
   logic [2:0]  fsmStateB;
   logic [7:0]  resultB;
   logic        busyB;
   logic        doneB;

   int checks   = 0;
   int failures = 0;

   pattern_regfile #(.DATA_W(16), .ADDR_W(4)) dutWide (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .sel(sel),
      .fsmState(fsmStateA), .currentResult(resultA), .busy(busyA), .done(doneA)
   );

   pattern_regfile #(.DATA_W(8), .ADDR_W(4)) dutNarrow (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .sel(sel),
      .fsmState(fsmStateB), .currentResult(resultB), .busy(busyB), .done(doneB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: n counts edges since the accepted start; reg i becomes visible once n reaches its write edge.
   int              widths [2] = '{16, 8};
   bit              active;
   int              n;
   longint unsigned oldR [2][DEPTH];
   longint unsigned newR [2][DEPTH];
   longint unsigned expResult [2];

   function automatic longint unsigned patternValue(input logic [1:0] m, input int w, input int i);
      longint unsigned msk = (64'd1 << w) - 64'd1;
      longint unsigned a, b, c;
      case (m)
         2'b00: begin a = 1; b = 2; end
         2'b01: begin a = 0; b = 1; end
         2'b10: begin a = 1; b = 3; end
         default: begin a = 0; b = 1; end
      endcase
      if (i == 0) return a;
      for (int k = 2; k <= i; k++) begin
         case (m)
            2'b00: c = (b * 2) & msk;
            2'b01: c = (a + b) & msk;
            2'b10: c = (b * 2 + 1) & msk;
            default: c = (b + 1) & msk;
         endcase
         a = b;
         b = c;
      end
      return b;
   endfunction

   function automatic longint unsigned viewReg(input int d, input int i);
      int writeEdge = (i < 2) ? 2 : i + 1;
      if (active && n >= writeEdge) return newR[d][i];
      return oldR[d][i];
   endfunction

   function automatic int expState();
      if (!active) return 0;
      if (n == 1) return 1;
      if (n < DEPTH) return 2;
      return 3;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         active = 1'b0;
         n      = 0;
         for (int d = 0; d < 2; d++) begin
            expResult[d] = 0;
            for (int i = 0; i < DEPTH; i++) begin
               oldR[d][i] = 0;
               newR[d][i] = 0;
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) expResult[d] = viewReg(d, int'(sel));
         if (start && (!active || n >= DEPTH)) begin
            for (int d = 0; d < 2; d++) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (active) oldR[d][i] = newR[d][i];
                  newR[d][i] = patternValue(mode, widths[d], i);
               end
            end
            active = 1'b1;
            n      = 1;
         end else if (active && n < DEPTH) begin
            n = n + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input longint unsigned actual, input longint unsigned expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (reset === 1'b1 || reset === 1'b0) begin
         checkOutput("wide.fsmState", fsmStateA, expState());
         checkOutput("wide.busy", busyA, (expState() == 1 || expState() == 2));
         checkOutput("wide.done", doneA, (expState() == 3));
         checkOutput("wide.result", resultA, expResult[0]);
         checkOutput("narrow.fsmState", fsmStateB, expState());
         checkOutput("narrow.busy", busyB, (expState() == 1 || expState() == 2));
         checkOutput("narrow.done", doneB, (expState() == 3));
         checkOutput("narrow.result", resultB, expResult[1]);
      end
   end

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [1:0] m);
      start = s;
      mode  = m;
      stepEdge();
      start = 1'b0;
   endtask

   task automatic readReg(input int i, input longint unsigned expWide, input longint unsigned expNarrow);
      sel = 4'(i);
      stepEdge();
      checkOutput($sformatf("wide.reg[%0d]", i), resultA, expWide);
      checkOutput($sformatf("narrow.reg[%0d]", i), resultB, expNarrow);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = 2'b00;
      sel   = 4'd0;
      #1 reset = 1'b0;
      #12;
      checkOutput("reset.fsmState", fsmStateA, 0);
      checkOutput("reset.result", resultA, 0);
      checkOutput("reset.busy", busyA, 0);
      checkOutput("reset.done", doneA, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) readReg(i, 0, 0);

      // Shift fill: DONE exactly 16 edges after start.
      applyStimulus(1'b1, 2'b00);
      repeat (15) stepEdge();
      checkOutput("shift.done", doneA, 1);
      checkOutput("shift.fsmState", fsmStateA, 3);
      for (int i = 0; i < DEPTH; i++) readReg(i, 64'd1 << i, (i < 8) ? (64'd1 << i) : 0);

      // Fibonacci restart from DONE.
      applyStimulus(1'b1, 2'b01);
      repeat (15) stepEdge();
      readReg(10, 55, 55);
      readReg(13, 233, 233);
      readReg(14, 377, 121);
      readReg(15, 610, 98);

      // Mask restart from DONE.
      applyStimulus(1'b1, 2'b10);
      repeat (15) stepEdge();
      readReg(3, 15, 15);
      readReg(15, 65535, 255);

      // Ramp with a start/mode change at edge 6 that must be ignored.
      applyStimulus(1'b1, 2'b11);
      repeat (4) stepEdge();
      applyStimulus(1'b1, 2'b00);
      repeat (9) stepEdge();
      checkOutput("ramp.busyBeforeDone", busyA, 1);
      stepEdge();
      checkOutput("ramp.done", doneA, 1);
      checkOutput("ramp.busyAtDone", busyA, 0);
      readReg(15, 15, 15);
      readReg(8, 8, 8);

      // Asynchronous reset between edges in the middle of a fill.
      applyStimulus(1'b1, 2'b00);
      repeat (5) stepEdge();
      #1 reset = 1'b0;
      #1;
      checkOutput("abort.fsmState", fsmStateA, 0);
      checkOutput("abort.result", resultA, 0);
      checkOutput("abort.busy", busyA, 0);
      checkOutput("abort.narrowResult", resultB, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      readReg(5, 0, 0);
      readReg(1, 0, 0);
      checkOutput("abort.idleAfterRelease", fsmStateA, 0);

      repeat (2) stepEdge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pattern_regfile.md
PATTERN_REGFILE -- requirements
Module: pattern_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and result width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, select width; DEPTH = 2**ADDR_W registers; ADDR_W >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin fill; sampled on clk rising edge.
REQ-006 SHALL have port mode  input  2  fill pattern: 00 shift, 01 fibonacci, 10 low-ones mask, 11 ramp.
REQ-007 SHALL have port sel  input  ADDR_W  index of the register to read out.
REQ-008 SHALL have port fsmState  output  3  encoded FSM state.
REQ-009 SHALL have port currentResult  output  DATA_W  registered contents of reg[sel].
REQ-010 SHALL have port busy  output  1  high in SEED and FILL.
REQ-011 SHALL have port done  output  1  high in DONE.

Function
REQ-012 SHALL implement states IDLE=0, SEED=1, FILL=2, DONE=3 on fsmState; codes 4-7 unused and SHALL recover to IDLE on the next edge.
REQ-013 IDLE: on an edge with start=1, SHALL latch mode into an internal mode register and go to SEED; otherwise stay.
REQ-014 SEED: on the next edge, SHALL write reg[0] and reg[1] with the seed pair (shift 1,2; fibonacci 0,1; mask 1,3; ramp 0,1), set the write index to 2, and go to FILL.
REQ-015 FILL: on each edge, SHALL write reg[idx] per the latched mode and increment idx.
REQ-016 Shift mode SHALL compute reg[i] = reg[i-1] << 1, truncated to DATA_W bits.
REQ-017 Fibonacci mode SHALL compute reg[i] = reg[i-1] + reg[i-2] mod 2**DATA_W.
REQ-018 Mask mode SHALL compute reg[i] = (reg[i-1] << 1) | 1, truncated to DATA_W bits.
REQ-019 Ramp mode SHALL compute reg[i] = reg[i-1] + 1 mod 2**DATA_W.
REQ-020 On the edge that writes reg[DEPTH-1], the FSM SHALL go to DONE; DONE is entered exactly DEPTH edges after the start edge (16 at default).
REQ-021 DONE: the FSM SHALL hold; start=1 SHALL re-latch mode and go to SEED; registers are overwritten, not cleared first.
REQ-022 start and mode changes while in SEED or FILL SHALL be ignored.
REQ-023 currentResult SHALL be loaded with reg[sel] on every edge in every state, giving a one-cycle read latency.
REQ-024 A read of the index being written on the same edge SHALL return the pre-write value.
REQ-025 busy and done SHALL be decoded combinationally from the state register.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, all DEPTH registers to 0, idx=0, latched mode=00, and currentResult=0; busy=0 and done=0 follow.
REQ-027 reset asserted mid-FILL SHALL abort the fill; after release, all registers read 0 until a new start.
REQ-028 The first edge after reset release SHALL behave as a normal IDLE edge.

Verification
REQ-029 Assert reset, then check fsmState=0, currentResult=0, busy=0, done=0; sweep sel 0..15 -> every read returns 0.
REQ-030 Default params, mode=00, pulse start, clock 16 edges -> done=1, fsmState=3; sweep sel=i with one edge each -> currentResult = 1<<i (1..32768).
REQ-031 Default params, mode=01 -> reg[10]=55, reg[15]=610; restart with mode=10 from DONE -> reg[3]=15, reg[15]=65535.
REQ-032 DATA_W=8, ADDR_W=4: shift -> reg[7]=128 and reg[8..15]=0; fibonacci -> reg[13]=233, reg[14]=121 (377 mod 256).
REQ-033 Start in mode 11; at edge 6 pulse start with mode=00 -> ignored; final reg[15]=15 and busy stays high until DONE.
REQ-034 Assert reset asynchronously mid-FILL (between edges) -> fsmState=0 and currentResult=0 before the next edge; sel=5 reads 0 after release.
